// File: rtl/alu_pkg.sv
// Shared types and ALU opcode constants for the execute/writeback stage.
package alu_pkg;

  localparam logic [7:0] ALU_ADD = 8'h00;
  localparam logic [7:0] ALU_SUB = 8'h01;
  localparam logic [7:0] ALU_OR  = 8'h04;
  localparam logic [7:0] ALU_AND = 8'h05;
  localparam logic [7:0] ALU_XOR = 8'h06;

  typedef logic [2:0] reg_idx_t;
  typedef logic [7:0] word_t;

  typedef struct packed {
    word_t    opcode;
    reg_idx_t rd;
    word_t    op0;
    word_t    op1;
  } ex_op_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decoded-op input channel and writeback channel of the execute stage.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic     in_valid;
  logic     in_ready;
  word_t    in_opcode;
  reg_idx_t in_rd;
  reg_idx_t in_rs0;
  reg_idx_t in_rs1;
  word_t    in_imm;
  logic     in_use_imm;

  logic     wb_valid;
  logic     wb_ready;
  reg_idx_t wb_rd;
  word_t    wb_data;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs0, in_rs1, in_imm, in_use_imm, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs0, in_rs1, in_imm, in_use_imm, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/regfile_8x8.sv
// Architectural register file: two operand read ports, one debug read port,
// one write port. Register 0 is hardwired to zero.
module regfile_8x8
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_ra0,
  input  logic [IDX_W-1:0] i_ra1,
  input  logic [IDX_W-1:0] i_rad,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wa,
  input  word_t            i_wd,
  output word_t            o_rd0,
  output word_t            o_rd1,
  output word_t            o_rdd
);

  word_t r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd0 = (i_ra0 == '0) ? '0 : r_mem[i_ra0];
  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rdd = (i_rad == '0) ? '0 : r_mem[i_rad];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage: one EX register feeding a combinational ALU,
// result written back to the register file on retirement.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int NREGS    = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_exec_stage_if.slave     bus,
  output word_t               alu_operand_0,
  output word_t               alu_operand_1,
  output word_t               alu_opcode,
  input  word_t               alu_result,
  output logic [RETIRE_W-1:0] retire_count,
  input  reg_idx_t            dbg_rsel,
  output word_t               dbg_rdata
);

  ex_op_t              r_ex;
  logic                r_ex_valid;
  logic [RETIRE_W-1:0] r_retire_count;

  logic  w_accept;
  logic  w_retire;
  word_t w_rf0;
  word_t w_rf1;
  word_t w_op0;
  word_t w_op1;

  // The retiring op's result is not in the file yet, so a same-cycle read
  // of its destination must take alu_result instead.
  function automatic word_t resolve(input reg_idx_t src, input word_t rf_val,
                                    input logic fwd_en, input reg_idx_t fwd_rd,
                                    input word_t fwd_val);
    if (src == '0) return '0;
    if (fwd_en && (fwd_rd == src)) return fwd_val;
    return rf_val;
  endfunction

  assign bus.in_ready = !r_ex_valid || bus.wb_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_retire     = r_ex_valid && bus.wb_ready;

  regfile_8x8 #(.NREGS(NREGS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ra0 (bus.in_rs0),
    .i_ra1 (bus.in_rs1),
    .i_rad (dbg_rsel),
    .i_we  (w_retire),
    .i_wa  (r_ex.rd),
    .i_wd  (alu_result),
    .o_rd0 (w_rf0),
    .o_rd1 (w_rf1),
    .o_rdd (dbg_rdata)
  );

  assign w_op0 = resolve(bus.in_rs0, w_rf0, w_retire, r_ex.rd, alu_result);
  assign w_op1 = bus.in_use_imm ? bus.in_imm
                                : resolve(bus.in_rs1, w_rf1, w_retire, r_ex.rd, alu_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex           <= '0;
      r_ex_valid     <= 1'b0;
      r_retire_count <= '0;
    end else begin
      if (w_accept) begin
        r_ex       <= '{opcode: bus.in_opcode, rd: bus.in_rd, op0: w_op0, op1: w_op1};
        r_ex_valid <= 1'b1;
      end else if (w_retire) begin
        r_ex_valid <= 1'b0;
      end
      if (w_retire) r_retire_count <= r_retire_count + 1'b1;
    end
  end

  assign alu_operand_0 = r_ex.op0;
  assign alu_operand_1 = r_ex.op1;
  assign alu_opcode    = r_ex.opcode;
  assign bus.wb_valid  = r_ex_valid;
  assign bus.wb_rd     = r_ex.rd;
  assign bus.wb_data   = alu_result;
  assign retire_count  = r_retire_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios plus random ops, checked
// against an architectural model of the register file and retirement.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  alu_operand_0, alu_operand_1, alu_opcode, alu_result;
  logic [15:0] retire_count;
  logic [2:0]  dbg_rsel;
  logic [7:0]  dbg_rdata;

  alu_exec_stage_if bus();

  alu_exec_stage #(.NREGS(8), .RETIRE_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .alu_operand_0 (alu_operand_0),
    .alu_operand_1 (alu_operand_1),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .retire_count  (retire_count),
    .dbg_rsel      (dbg_rsel),
    .dbg_rdata     (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_XOR: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  // Combinational ALU downstream of the stage
  always_comb alu_result = alu_f(alu_opcode, alu_operand_0, alu_operand_1);

  // Architectural model: register values, op in flight, retirement count
  logic [7:0]  m_regs [8];
  logic        m_v;
  logic [2:0]  m_rd;
  logic [7:0]  m_res;
  logic [15:0] m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_v = 1'b0; m_rd = 3'd0; m_res = 8'h00; m_cnt = 16'd0;
  endtask

  task automatic dump(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_rsel = 3'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), 32'(dbg_rdata), 32'(m_regs[i]));
    end
  endtask

  // One clock: drive at negedge, check, advance model, let the edge happen.
  task automatic cycle(input logic v, input logic [7:0] op, input logic [2:0] rd,
                       input logic [2:0] rs0, input logic [2:0] rs1,
                       input logic [7:0] imm, input logic ui, input logic wbr);
    logic exp_rdy;
    logic [7:0] a, b;
    @(negedge clk);
    bus.in_valid = v;   bus.in_opcode = op; bus.in_rd = rd;
    bus.in_rs0 = rs0;   bus.in_rs1 = rs1;   bus.in_imm = imm;
    bus.in_use_imm = ui; bus.wb_ready = wbr;
    #1;
    exp_rdy = !m_v || wbr;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("wb_valid", 32'(bus.wb_valid), 32'(m_v));
    chk("retire_count", 32'(retire_count), 32'(m_cnt));
    if (m_v) begin
      chk("wb_data", 32'(bus.wb_data), 32'(m_res));
      chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
    end
    if (m_v && wbr) begin
      if (m_rd != 3'd0) m_regs[m_rd] = m_res;
      m_cnt++;
      m_v = 1'b0;
    end
    if (v && exp_rdy) begin
      a = m_regs[rs0];
      b = ui ? imm : m_regs[rs1];
      m_res = alu_f(op, a, b);
      m_rd = rd;
      m_v = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  logic [7:0] ops [7];

  initial begin
    ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_OR; ops[3] = ALU_AND;
    ops[4] = ALU_XOR; ops[5] = 8'h02;   ops[6] = 8'hFF;
    bus.in_valid = 1'b0; bus.in_opcode = 8'h00; bus.in_rd = 3'd0;
    bus.in_rs0 = 3'd0;   bus.in_rs1 = 3'd0;     bus.in_imm = 8'h00;
    bus.in_use_imm = 1'b0; bus.wb_ready = 1'b0; dbg_rsel = 3'd0;
    model_reset();

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_count", 32'(retire_count), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_op0", 32'(alu_operand_0), 32'd0);
    chk("rst_alu_op1", 32'(alu_operand_1), 32'd0);
    dump("rst_regs");

    // Back-to-back with forwarding
    cycle(1, ALU_ADD, 3'd1, 3'd0, 3'd0, 8'd5, 1, 1);
    cycle(1, ALU_ADD, 3'd2, 3'd1, 3'd1, 8'd0, 0, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    dump("fwd_regs");

    // Backpressure: SUB r3 = 0 - 1 held, then released with dependent op
    cycle(1, ALU_SUB, 3'd3, 3'd0, 3'd0, 8'd1, 1, 0);
    cycle(1, ALU_ADD, 3'd5, 3'd3, 3'd0, 8'd1, 1, 0);
    cycle(1, ALU_ADD, 3'd5, 3'd3, 3'd0, 8'd1, 1, 0);
    dump("bp_regs");
    cycle(1, ALU_ADD, 3'd5, 3'd3, 3'd0, 8'd1, 1, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    dump("bp_rel_regs");

    // r0 write and undefined opcode
    cycle(1, ALU_XOR, 3'd0, 3'd0, 3'd0, 8'hAA, 1, 1);
    cycle(1, 8'h02,   3'd4, 3'd1, 3'd0, 8'h07, 1, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    dump("r0_undef_regs");

    // Logic ops on r1=F0, r2=3C
    cycle(1, ALU_ADD, 3'd1, 3'd0, 3'd0, 8'hF0, 1, 1);
    cycle(1, ALU_ADD, 3'd2, 3'd0, 3'd0, 8'h3C, 1, 1);
    cycle(1, ALU_OR,  3'd6, 3'd1, 3'd2, 8'h00, 0, 1);
    cycle(1, ALU_AND, 3'd7, 3'd1, 3'd2, 8'h00, 0, 1);
    cycle(1, ALU_XOR, 3'd3, 3'd1, 3'd2, 8'h00, 0, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    dump("logic_regs");

    // Random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), ops[$urandom_range(0, 6)],
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    dump("rand_regs");

    // Reset while an op waits for writeback
    cycle(1, ALU_SUB, 3'd3, 3'd0, 3'd0, 8'd1, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_count", 32'(retire_count), 32'd0);
    chk("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
    model_reset();
    dump("midrst_regs");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, ALU_ADD, 3'd2, 3'd0, 3'd0, 8'h11, 1, 1);
    cycle(0, ALU_ADD, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    dump("post_rst_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage directly upstream of the 8-bit ALU. Owns the 8-entry, 8-bit architectural register file.
- Accepts decoded ops over a valid/ready handshake and reads operands, forwarding from the retiring op when needed.
- Holds the op in a single EX register that drives the ALU. Captures the ALU result, writes it back to the register file, and reports each retirement on a valid/ready writeback port.

Parameters:
- NREGS, 8, number of architectural registers; index width is $clog2(NREGS).
- RETIRE_W, 16, width of the retired-op counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded op offered
- in_ready  output  1  stage can accept the op
- in_opcode  input  8  ALU opcode (package constants)
- in_rd  input  3  destination register
- in_rs0  input  3  source register for operand_0
- in_rs1  input  3  source register for operand_1 (ignored when in_use_imm=1)
- in_imm  input  8  immediate for operand_1
- in_use_imm  input  1  operand_1 := in_imm
- alu_operand_0  output  8  to ALU operand_0
- alu_operand_1  output  8  to ALU operand_1
- alu_opcode  output  8  to ALU opcode
- alu_result  input  8  from ALU result (combinational)
- wb_valid  output  1  op in EX is retiring/offered
- wb_ready  input  1  consumer accepts retirement
- wb_rd  output  3  destination of retiring op
- wb_data  output  8  equals alu_result
- retire_count  output  RETIRE_W  number of retired ops
- dbg_rsel  input  3  debug register select
- dbg_rdata  output  8  combinational read of regfile[dbg_rsel]

Behaviour:
- Reset (async, rst_n=0):
  - ex_valid=0; EX opcode/rd/operands=0, so alu_* outputs are 0.
  - All registers 0; retire_count=0.
  - in_ready=1 after reset; wb_valid=0; wb_rd=0.
  - Reset asserted mid-operation discards the EX op with no writeback.
- Handshake:
  - Accept = in_valid && in_ready.
  - Retire = ex_valid && wb_ready.
  - in_ready = !ex_valid || wb_ready, combinationally. This gives one op per cycle sustained and full-through on retire.
  - in_* inputs are sampled only on accept. in_valid may drop without acceptance.
- Latency and outputs:
  - An op accepted at edge N drives the ALU from the cycle after edge N.
  - wb_valid=1 in that same cycle; the ALU is combinational, so result visibility is 1 cycle after accept.
  - wb_valid = ex_valid; wb_data = alu_result; wb_rd = EX rd.
  - Outputs stay stable while wb_valid && !wb_ready.
- EX update on each edge:
  - Accept: load op and resolved operands; ex_valid=1.
  - Else if retire: ex_valid=0, payload held.
  - Else: hold.
- Writeback: on retire, regfile[EX rd] <= alu_result and retire_count += 1, wrapping modulo 2^RETIRE_W.
- Register 0: reads as 0 always. Writes to r0 are dropped, but the op still retires and is still counted.
- Operand resolution at accept:
  - Source r0 gives 0.
  - Else if retire this cycle and EX rd == source and EX rd != 0, use alu_result (forwarding).
  - Else use regfile[source].
  - operand_1 uses in_imm when in_use_imm=1, with no forwarding.
  - Same-cycle retire+accept with rd==rs must not produce a stale read.
- Opcode handling: opcodes are passed through unchecked. Undefined opcodes yield ALU result 0, which is written back normally.
- Debug read:
  - dbg_rdata reflects the register file state after the last edge; no forwarding.
  - dbg_rsel=0 gives 0.
- Arithmetic is 8-bit modular inside the ALU. This block does no width extension.

Decomposition:
- Package alu_pkg holds:
  - the opcode constants ALU_ADD=8'h00, ALU_SUB=8'h01, ALU_OR=8'h04, ALU_AND=8'h05, ALU_XOR=8'h06
  - typedef reg_idx_t (logic [2:0])
  - typedef word_t (logic [7:0])
  - a packed struct ex_op_t {opcode, rd, op0, op1}
- One sub-module is natural: regfile_8x8, with two combinational read ports, one debug read port and one write port with async reset. r0 handling lives inside it.

Test Plan:
- Reset check: after reset, drive dbg_rsel=0..7 -> every dbg_rdata=0; in_ready=1, wb_valid=0, retire_count=0.
- Immediate back-to-back with forwarding: ADD r1=r0+imm 5, then next cycle ADD r2=r1+r1, with wb_ready=1 -> wb_data 5 then 10; regfile r1=5, r2=10; retire_count=2.
- Backpressure: hold wb_ready=0 with an op in EX (SUB r3=r0-imm 1) -> wb_data=8'hFF stable, in_ready=0, second op not accepted, r3 unwritten. Release -> r3=8'hFF, second op accepted the same cycle.
- r0 and undefined opcode: XOR r0=r0^imm 8'hAA -> r0 reads 0, retire counted. Opcode 8'h02 into r4 -> r4=0.
- Logic ops: r1=8'hF0, r2=8'h3C -> OR=8'hFC, AND=8'h30, XOR=8'hCC, each written to a distinct rd.
- Reset mid-flight: assert rst_n=0 while wb_valid=1 and wb_ready=0 -> wb_valid drops asynchronously, no write, all registers 0.
